triangle_setup: RTL and testbench



---
 rtl/triangle_setup.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// Triangle setup stage: accepts one screen-space triangle per valid/ready handshake and derives
// the three edge functions E_k(x,y) = A_k*x + B_k*y + C_k, one edge per cycle over a shared
// multiplier pair. It also accumulates the doubled signed area and the raw bounding box, rejects
// degenerate, culled or fully offscreen triangles, normalises the winding so that the inside is
// positive, and clamps the bounding box to the screen.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   triangle input handshake
//   vertexes              3 vertices x {x,y,z}; vertex v component c (0=x,1=y,2=z) sits at
//                         bits [(3*v+c)*COORD_WIDTH +: COORD_WIDTH], signed; z is ignored
//   out_valid / out_ready result handshake
//   bound_coefs           edge k: A_k at slot 2*k, B_k at slot 2*k+1, each COORD_WIDTH+1 signed
//   bound_const           edge k: C_k at slot k, each 2*COORD_WIDTH+2 signed
//   bbox_min/max_x/y      bounding box clamped to the screen
//   flipped               input winding was negative and outputs were negated
//   dropped               one-cycle pulse when a triangle is rejected
module triangle_setup #(
    parameter int COORD_WIDTH   = 16,
    parameter int SCREEN_X_SIZE = 800,
    parameter int SCREEN_Y_SIZE = 600,
    parameter int CULL_MODE     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [9*COORD_WIDTH-1:0]             vertexes,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [6*(COORD_WIDTH+1)-1:0]         bound_coefs,
    output logic [3*(2*COORD_WIDTH+2)-1:0]       bound_const,
    output logic [$clog2(SCREEN_X_SIZE)-1:0]     bbox_min_x,
    output logic [$clog2(SCREEN_X_SIZE)-1:0]     bbox_max_x,
    output logic [$clog2(SCREEN_Y_SIZE)-1:0]     bbox_min_y,
    output logic [$clog2(SCREEN_Y_SIZE)-1:0]     bbox_max_y,
    output logic                                 flipped,
    output logic                                 dropped
);

    localparam int CW = COORD_WIDTH;
    localparam int KW = 2 * CW + 2;   // edge constant width
    localparam int AW = 2 * CW + 4;   // area accumulator width
    localparam int XW = $clog2(SCREEN_X_SIZE);
    localparam int YW = $clog2(SCREEN_Y_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StEdge0,
        StEdge1,
        StEdge2,
        StClassify,
        StOut
    } state_e;

    state_e state_q, state_d;

    // Latched vertices
    logic signed [CW-1:0] vx_q [3];
    logic signed [CW-1:0] vy_q [3];

    // Working registers filled during the edge cycles
    logic signed [CW:0]   a_q [3];
    logic signed [CW:0]   b_q [3];
    logic signed [KW-1:0] c_q [3];
    logic signed [AW-1:0] area_q;
    logic signed [CW-1:0] min_x_q, max_x_q, min_y_q, max_y_q;

    // Output registers; only updated when a triangle is accepted
    logic signed [CW:0]   oa_q [3];
    logic signed [CW:0]   ob_q [3];
    logic signed [KW-1:0] oc_q [3];
    logic [XW-1:0]        bbox_min_x_q, bbox_max_x_q;
    logic [YW-1:0]        bbox_min_y_q, bbox_max_y_q;
    logic                 flipped_q;
    logic                 dropped_q, dropped_d;

    // z components carry no information for setup
    logic unused_z;
    assign unused_z = ^{vertexes[2*CW +: CW], vertexes[5*CW +: CW], vertexes[8*CW +: CW]};

    // ------------------------------------------------------------------
    // Edge datapath: edge k uses vertex i = k and j = (k+1)%3
    // ------------------------------------------------------------------
    logic [1:0]           edge_idx;
    logic                 in_edge;
    logic                 first_edge;
    logic signed [CW-1:0] xi, yi, xj, yj;
    logic signed [2*CW-1:0] prod_ij, prod_ji;
    logic signed [CW:0]   edge_a, edge_b;
    logic signed [KW-1:0] edge_c;
    logic signed [AW-1:0] area_base, area_sum;
    logic signed [CW-1:0] min_x_d, max_x_d, min_y_d, max_y_d;

    always_comb begin
        edge_idx = 2'd0;
        case (state_q)
            StEdge1: edge_idx = 2'd1;
            StEdge2: edge_idx = 2'd2;
            default: edge_idx = 2'd0;
        endcase
    end

    assign in_edge    = (state_q == StEdge0) || (state_q == StEdge1) || (state_q == StEdge2);
    assign first_edge = (state_q == StEdge0);

    always_comb begin
        xi = vx_q[0];
        yi = vy_q[0];
        xj = vx_q[1];
        yj = vy_q[1];
        case (edge_idx)
            2'd1: begin
                xi = vx_q[1];
                yi = vy_q[1];
                xj = vx_q[2];
                yj = vy_q[2];
            end
            2'd2: begin
                xi = vx_q[2];
                yi = vy_q[2];
                xj = vx_q[0];
                yj = vy_q[0];
            end
            default: ;
        endcase
    end

    // Shared multiplier pair, operands sign-extended so the 2*CW product is exact
    assign prod_ij = $signed({{CW{xi[CW-1]}}, xi}) * $signed({{CW{yj[CW-1]}}, yj});
    assign prod_ji = $signed({{CW{xj[CW-1]}}, xj}) * $signed({{CW{yi[CW-1]}}, yi});

    assign edge_a = $signed({yi[CW-1], yi}) - $signed({yj[CW-1], yj});
    assign edge_b = $signed({xj[CW-1], xj}) - $signed({xi[CW-1], xi});
    assign edge_c = $signed({{2{prod_ij[2*CW-1]}}, prod_ij})
                  - $signed({{2{prod_ji[2*CW-1]}}, prod_ji});

    assign area_base = first_edge ? '0 : area_q;
    assign area_sum  = area_base + $signed({{2{edge_c[KW-1]}}, edge_c});

    // Running raw bounds include vertex i of the current edge
    assign min_x_d = (first_edge || (xi < min_x_q)) ? xi : min_x_q;
    assign max_x_d = (first_edge || (xi > max_x_q)) ? xi : max_x_q;
    assign min_y_d = (first_edge || (yi < min_y_q)) ? yi : min_y_q;
    assign max_y_d = (first_edge || (yi > max_y_q)) ? yi : max_y_q;

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    logic area_zero, area_neg, cull_rej, off_rej, reject, accept_out;
    logic [XW-1:0] clamp_min_x, clamp_max_x;
    logic [YW-1:0] clamp_min_y, clamp_max_y;

    assign area_zero = (area_q == '0);
    assign area_neg  = area_q[AW-1];
    assign cull_rej  = ((CULL_MODE == 1) && area_neg)
                    || ((CULL_MODE == 2) && !area_neg && !area_zero);
    assign off_rej   = max_x_q[CW-1] || max_y_q[CW-1]
                    || (int'(min_x_q) >= SCREEN_X_SIZE)
                    || (int'(min_y_q) >= SCREEN_Y_SIZE);
    assign reject    = area_zero || cull_rej || off_rej;

    assign accept_out = (state_q == StClassify) && !reject;
    assign dropped_d  = (state_q == StClassify) && reject;

    // Offscreen triangles are already rejected, so min < SIZE and max >= 0 here
    assign clamp_min_x = min_x_q[CW-1] ? '0 : min_x_q[XW-1:0];
    assign clamp_min_y = min_y_q[CW-1] ? '0 : min_y_q[YW-1:0];
    assign clamp_max_x = (int'(max_x_q) > SCREEN_X_SIZE - 1) ? XW'(SCREEN_X_SIZE - 1)
                                                             : max_x_q[XW-1:0];
    assign clamp_max_y = (int'(max_y_q) > SCREEN_Y_SIZE - 1) ? YW'(SCREEN_Y_SIZE - 1)
                                                             : max_y_q[YW-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (in_valid) state_d = StEdge0;
            StEdge0:    state_d = StEdge1;
            StEdge1:    state_d = StEdge2;
            StEdge2:    state_d = StClassify;
            StClassify: state_d = reject ? StIdle : StOut;
            StOut:      if (out_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Vertex latch and working registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < 3; v++) begin
                vx_q[v] <= '0;
                vy_q[v] <= '0;
                a_q[v]  <= '0;
                b_q[v]  <= '0;
                c_q[v]  <= '0;
            end
            area_q  <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
        end else begin
            if (in_ready && in_valid) begin
                for (int v = 0; v < 3; v++) begin
                    vx_q[v] <= vertexes[(3*v)*CW +: CW];
                    vy_q[v] <= vertexes[(3*v+1)*CW +: CW];
                end
            end
            if (in_edge) begin
                for (int k = 0; k < 3; k++) begin
                    if (edge_idx == 2'(k)) begin
                        a_q[k] <= edge_a;
                        b_q[k] <= edge_b;
                        c_q[k] <= edge_c;
                    end
                end
                area_q  <= area_sum;
                min_x_q <= min_x_d;
                max_x_q <= max_x_d;
                min_y_q <= min_y_d;
                max_y_q <= max_y_d;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                oa_q[k] <= '0;
                ob_q[k] <= '0;
                oc_q[k] <= '0;
            end
            bbox_min_x_q <= '0;
            bbox_max_x_q <= '0;
            bbox_min_y_q <= '0;
            bbox_max_y_q <= '0;
            flipped_q    <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            dropped_q <= dropped_d;
            if (accept_out) begin
                // Negation cannot overflow: |A|,|B| <= 2^CW - 1 and C has two guard bits
                for (int k = 0; k < 3; k++) begin
                    oa_q[k] <= area_neg ? -a_q[k] : a_q[k];
                    ob_q[k] <= area_neg ? -b_q[k] : b_q[k];
                    oc_q[k] <= area_neg ? -c_q[k] : c_q[k];
                end
                bbox_min_x_q <= clamp_min_x;
                bbox_max_x_q <= clamp_max_x;
                bbox_min_y_q <= clamp_min_y;
                bbox_max_y_q <= clamp_max_y;
                flipped_q    <= area_neg;
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_out
        assign bound_coefs[(2*k)*(CW+1) +: CW+1]   = oa_q[k];
        assign bound_coefs[(2*k+1)*(CW+1) +: CW+1] = ob_q[k];
        assign bound_const[k*KW +: KW]             = oc_q[k];
    end

    assign bbox_min_x = bbox_min_x_q;
    assign bbox_max_x = bbox_max_x_q;
    assign bbox_min_y = bbox_min_y_q;
    assign bbox_max_y = bbox_max_y_q;
    assign flipped    = flipped_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_triangle_setup.sv
module tb_triangle_setup;

    localparam int CW = 16;
    localparam int KW = 2 * CW + 2;
    localparam int XW = 10;
    localparam int YW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_valid1 = 1'b0;
    logic out_ready = 1'b0;
    logic out_ready1 = 1'b1;
    logic [9*CW-1:0] vertexes = '0;

    logic in_ready, out_valid, flipped, dropped;
    logic [6*(CW+1)-1:0] bound_coefs;
    logic [3*KW-1:0] bound_const;
    logic [XW-1:0] bbox_min_x, bbox_max_x;
    logic [YW-1:0] bbox_min_y, bbox_max_y;

    logic in_ready1, out_valid1, flipped1, dropped1;
    logic [6*(CW+1)-1:0] bound_coefs1;
    logic [3*KW-1:0] bound_const1;
    logic [XW-1:0] bbox_min_x1, bbox_max_x1;
    logic [YW-1:0] bbox_min_y1, bbox_max_y1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    triangle_setup #(
        .COORD_WIDTH(CW), .SCREEN_X_SIZE(800), .SCREEN_Y_SIZE(600), .CULL_MODE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .vertexes(vertexes), .out_valid(out_valid), .out_ready(out_ready),
        .bound_coefs(bound_coefs), .bound_const(bound_const),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .flipped(flipped), .dropped(dropped)
    );

    triangle_setup #(
        .COORD_WIDTH(CW), .SCREEN_X_SIZE(800), .SCREEN_Y_SIZE(600), .CULL_MODE(1)
    ) dut_cull (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .vertexes(vertexes), .out_valid(out_valid1), .out_ready(out_ready1),
        .bound_coefs(bound_coefs1), .bound_const(bound_const1),
        .bbox_min_x(bbox_min_x1), .bbox_max_x(bbox_max_x1),
        .bbox_min_y(bbox_min_y1), .bbox_max_y(bbox_max_y1),
        .flipped(flipped1), .dropped(dropped1)
    );

    function automatic int get_a(input int k);
        logic signed [CW:0] v;
        v = bound_coefs[(2*k)*(CW+1) +: CW+1];
        return int'(v);
    endfunction

    function automatic int get_b(input int k);
        logic signed [CW:0] v;
        v = bound_coefs[(2*k+1)*(CW+1) +: CW+1];
        return int'(v);
    endfunction

    function automatic longint get_c(input int k);
        logic signed [KW-1:0] v;
        v = bound_const[k*KW +: KW];
        return longint'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        vertexes[0*CW +: CW] = CW'(x0);
        vertexes[1*CW +: CW] = CW'(y0);
        vertexes[2*CW +: CW] = 16'h1234;
        vertexes[3*CW +: CW] = CW'(x1);
        vertexes[4*CW +: CW] = CW'(y1);
        vertexes[5*CW +: CW] = 16'h7fff;
        vertexes[6*CW +: CW] = CW'(x2);
        vertexes[7*CW +: CW] = CW'(y2);
        vertexes[8*CW +: CW] = 16'h8000;
    endtask

    // Present a triangle for one cycle on the main instance; returns in cycle T+1
    task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        set_tri(x0, y0, x1, y1, x2, y2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if ({out_valid, dropped, flipped} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {out_valid, dropped, flipped});
        end
        total++;
        if (bound_coefs !== '0 || bound_const !== '0) begin
            bad++;
            $display("FAIL reset_coefs: got %h/%h want 0", bound_coefs, bound_const);
        end
        total++;
        if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== '0) begin
            bad++;
            $display("FAIL reset_bbox: got %0d %0d %0d %0d want 0", bbox_min_x, bbox_max_x,
                     bbox_min_y, bbox_max_y);
        end
    endtask

    task automatic test_ccw();
        int exp_a[3] = '{0, -10, 10};
        int exp_b[3] = '{10, -10, 0};
        longint exp_c[3] = '{0, 100, 0};
        longint exp_e[3] = '{10, 80, 10};
        longint e;
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ccw_in_ready: got %b want 1", in_ready);
        end
        send_tri(0, 0, 10, 0, 0, 10);
        for (int c = 1; c < 5; c++) begin
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL ccw_latency c=%0d: got v=%b r=%b want 0 0", c, out_valid,
                         in_ready);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b1 || dropped !== 1'b0 || flipped !== 1'b0) begin
            bad++;
            $display("FAIL ccw_out: got v=%b d=%b f=%b want 1 0 0", out_valid, dropped, flipped);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (get_a(k) !== exp_a[k] || get_b(k) !== exp_b[k] || get_c(k) !== exp_c[k]) begin
                bad++;
                $display("FAIL ccw_edge%0d: got %0d %0d %0d want %0d %0d %0d", k, get_a(k),
                         get_b(k), get_c(k), exp_a[k], exp_b[k], exp_c[k]);
            end
            e = longint'(get_a(k)) + longint'(get_b(k)) + get_c(k);
            total++;
            if (e !== exp_e[k]) begin
                bad++;
                $display("FAIL ccw_eval%0d: got %0d want %0d", k, e, exp_e[k]);
            end
        end
        total++;
        if (bbox_min_x !== 10'd0 || bbox_max_x !== 10'd10 || bbox_min_y !== 10'd0 ||
            bbox_max_y !== 10'd10) begin
            bad++;
            $display("FAIL ccw_bbox: got %0d..%0d %0d..%0d want 0..10 0..10", bbox_min_x,
                     bbox_max_x, bbox_min_y, bbox_max_y);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ccw_release: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reversed();
        int exp_a[3] = '{10, -10, 0};
        int exp_b[3] = '{0, -10, 10};
        longint exp_c[3] = '{0, 100, 0};
        longint area;
        out_ready = 1'b1;
        send_tri(0, 0, 0, 10, 10, 0);
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b1 || flipped !== 1'b1 || dropped !== 1'b0) begin
            bad++;
            $display("FAIL rev_out: got v=%b f=%b d=%b want 1 1 0", out_valid, flipped, dropped);
        end
        area = 0;
        for (int k = 0; k < 3; k++) begin
            area += get_c(k);
            total++;
            if (get_a(k) !== exp_a[k] || get_b(k) !== exp_b[k] || get_c(k) !== exp_c[k]) begin
                bad++;
                $display("FAIL rev_edge%0d: got %0d %0d %0d want %0d %0d %0d", k, get_a(k),
                         get_b(k), get_c(k), exp_a[k], exp_b[k], exp_c[k]);
            end
        end
        total++;
        if (area !== 100) begin
            bad++;
            $display("FAIL rev_area: got %0d want 100", area);
        end
        tick();
    endtask

    task automatic test_cull();
        set_tri(0, 0, 0, 10, 10, 0);
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        for (int c = 1; c < 5; c++) begin
            total++;
            if (dropped1 !== 1'b0 || out_valid1 !== 1'b0) begin
                bad++;
                $display("FAIL cull_early c=%0d: got d=%b v=%b want 0 0", c, dropped1, out_valid1);
            end
            tick();
        end
        total++;
        if (dropped1 !== 1'b1 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL cull_drop: got d=%b v=%b want 1 0", dropped1, out_valid1);
        end
        tick();
        total++;
        if (dropped1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL cull_after: got d=%b v=%b r=%b want 0 0 1", dropped1, out_valid1,
                     in_ready1);
        end
    endtask

    // Previous accepted result is the reversed triangle: flipped=1, C_1=100
    task automatic test_rejects();
        for (int t = 0; t < 2; t++) begin
            if (t == 0) send_tri(0, 0, 5, 5, 10, 10);
            else send_tri(900, 0, 1000, 0, 900, 50);
            repeat (3) tick();
            total++;
            if (dropped !== 1'b0) begin
                bad++;
                $display("FAIL rej%0d_early: got d=%b want 0", t, dropped);
            end
            tick();
            total++;
            if (dropped !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rej%0d_drop: got d=%b v=%b want 1 0", t, dropped, out_valid);
            end
            total++;
            if (flipped !== 1'b1 || get_c(1) !== 100 || bbox_max_x !== 10'd10) begin
                bad++;
                $display("FAIL rej%0d_hold: got f=%b c1=%0d mx=%0d want 1 100 10", t, flipped,
                         get_c(1), bbox_max_x);
            end
            tick();
            total++;
            if (dropped !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rej%0d_after: got d=%b v=%b r=%b want 0 0 1", t, dropped,
                         out_valid, in_ready);
            end
        end
    endtask

    task automatic test_clamp();
        out_ready = 1'b1;
        send_tri(-20, -20, 900, 0, 0, 700);
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b1 || flipped !== 1'b0) begin
            bad++;
            $display("FAIL clamp_out: got v=%b f=%b want 1 0", out_valid, flipped);
        end
        total++;
        if (bbox_min_x !== 10'd0 || bbox_max_x !== 10'd799 || bbox_min_y !== 10'd0 ||
            bbox_max_y !== 10'd599) begin
            bad++;
            $display("FAIL clamp_bbox: got %0d..%0d %0d..%0d want 0..799 0..599", bbox_min_x,
                     bbox_max_x, bbox_min_y, bbox_max_y);
        end
        total++;
        if (get_a(1) !== -700 || get_b(1) !== -900 || get_c(1) !== 630000) begin
            bad++;
            $display("FAIL clamp_edge1: got %0d %0d %0d want -700 -900 630000", get_a(1),
                     get_b(1), get_c(1));
        end
        tick();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        send_tri(0, 0, 10, 0, 0, 10);
        repeat (4) tick();
        // Offer a different triangle while the result is held; it must wait
        set_tri(-20, -20, 900, 0, 0, 700);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || get_c(1) !== 100 ||
                bbox_max_x !== 10'd10 || get_a(1) !== -10) begin
                bad++;
                $display("FAIL hold c=%0d: got v=%b r=%b c1=%0d mx=%0d a1=%0d want 1 0 100 10 -10",
                         c, out_valid, in_ready, get_c(1), bbox_max_x, get_a(1));
            end
            tick();
        end
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_last: got v=%b want 1", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b1 || bbox_max_x !== 10'd799 || bbox_max_y !== 10'd599) begin
            bad++;
            $display("FAIL hold_next: got v=%b mx=%0d my=%0d want 1 799 599", out_valid,
                     bbox_max_x, bbox_max_y);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_tri(0, 0, 10, 0, 0, 10);
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dropped !== 1'b0 ||
            flipped !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_flags: got v=%b r=%b d=%b f=%b want 0 1 0 0", out_valid,
                     in_ready, dropped, flipped);
        end
        total++;
        if (bound_coefs !== '0 || bound_const !== '0 || bbox_max_x !== '0 ||
            bbox_max_y !== '0) begin
            bad++;
            $display("FAIL rst_mid_data: got %h %h %0d %0d want 0", bound_coefs, bound_const,
                     bbox_max_x, bbox_max_y);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            total++;
            if (out_valid !== 1'b0 || dropped !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rst_mid_quiet c=%0d: got v=%b d=%b r=%b want 0 0 1", c, out_valid,
                         dropped, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_tri(0, 0, 10, 0, 0, 10);
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b1 || flipped !== 1'b0 || get_b(0) !== 10) begin
            bad++;
            $display("FAIL b2b_first: got v=%b f=%b b0=%0d want 1 0 10", out_valid, flipped,
                     get_b(0));
        end
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        send_tri(0, 0, 0, 10, 10, 0);
        repeat (4) tick();
        total++;
        if (out_valid !== 1'b1 || flipped !== 1'b1 || get_a(0) !== 10 || get_c(1) !== 100) begin
            bad++;
            $display("FAIL b2b_second: got v=%b f=%b a0=%0d c1=%0d want 1 1 10 100", out_valid,
                     flipped, get_a(0), get_c(1));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ccw();
        test_reversed();
        test_cull();
        test_rejects();
        test_clamp();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
